instr_aligner: RTL and testbench

- Fetch-side realignment stage that sits directly upstream of the decode/control block.
- Accepts a stream of 32-bit word-aligned fetch words and buffers them as halfwords.
- Emits one complete instruction per handshake, either 16-bit compressed (zero-extended) or 32-bit, together with its PC.
- Handles 32-bit instructions that straddle a word boundary, and branch/jump redirects to halfword-aligned targets.

---
 rtl/instr_aligner.sv | 163 ++++++++++++++++
 tb/tb_instr_aligner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_aligner.sv
// instr_aligner: fetch-side realignment stage. Buffers 32-bit fetch words as halfwords and
// presents one complete instruction (16-bit compressed or 32-bit) per decode handshake.
// Optional feature macro: COMPRESSED_EN (RVC support). When undefined, every instruction is
// 32-bit and a redirect to a halfword-only-aligned target raises a sticky instr_fault.
// Note: reset_n is active-high (1 = reset asserted) despite its name.
module instr_aligner #(
    parameter int unsigned BUF_HW   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_compressed,
    output logic        instr_fault
);

    localparam int unsigned CW = $clog2(BUF_HW + 1);

    logic [15:0]   hw_q [BUF_HW];
    logic [15:0]   hw_d [BUF_HW];
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q, pc_d;

    logic          head16, head32, fault_pres;
    logic          accept, consume;
    logic [1:0]    pop_n, push_n;
    logic [15:0]   push_first;

    // Bit 0 of the redirect target is ignored by design.
    logic          unused_flush_pc0;
    assign unused_flush_pc0 = flush_pc[0];

`ifdef COMPRESSED_EN
    logic drop_q, drop_d;

    assign head16     = (count_q >= CW'(1)) && (hw_q[0][1:0] != 2'b11);
    assign fault_pres = 1'b0;
    assign push_n     = accept ? (drop_q ? 2'd1 : 2'd2) : 2'd0;
    assign push_first = drop_q ? word_data[31:16] : word_data[15:0];
`else
    logic fault_q, fault_d;
    // After the fault has been consumed, fetch words are discarded until a redirect.
    logic block_q, block_d;

    assign head16     = 1'b0;
    assign fault_pres = fault_q;
    assign push_n     = (accept && !fault_q && !block_q) ? 2'd2 : 2'd0;
    assign push_first = word_data[15:0];
`endif

    assign head32 = !head16 && (count_q >= CW'(2));

    // Outputs are a pure function of buffer state, so they hold while decode stalls.
    always_comb begin
        instr_valid      = fault_pres | head16 | head32;
        instr_pc         = pc_q;
        instr_compressed = head16;
        instr_fault      = fault_pres;
        if (head16) begin
            instruction = {16'h0000, hw_q[0]};
        end else if (head32) begin
            instruction = {hw_q[1], hw_q[0]};
        end else begin
            instruction = 32'h0000_0000;
        end
    end

    assign word_ready = !reset_n && (count_q <= CW'(BUF_HW - 2));
    assign accept     = word_valid && word_ready;
    assign consume    = instr_valid && instr_ready;
    assign pop_n      = (consume && !fault_pres) ? (head16 ? 2'd1 : 2'd2) : 2'd0;

    // Buffer next state: drop popped halfwords from the head, then append at the new tail.
    always_comb begin
        int wr_idx;
        for (int i = 0; i < int'(BUF_HW); i++) begin
            hw_d[i] = hw_q[i];
            for (int j = 0; j < int'(BUF_HW); j++) begin
                if (j == i + int'(pop_n)) begin
                    hw_d[i] = hw_q[j];
                end
            end
        end
        wr_idx = int'(count_q) - int'(pop_n);
        for (int i = 0; i < int'(BUF_HW); i++) begin
            if (push_n != 2'd0 && i == wr_idx) begin
                hw_d[i] = push_first;
            end
            if (push_n == 2'd2 && i == wr_idx + 1) begin
                hw_d[i] = word_data[31:16];
            end
        end
    end

    // Count, PC and mode-specific flags; a flush overrides everything except reset.
    always_comb begin
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        pc_d    = pc_q + ((pop_n == 2'd1) ? 32'd2 : (pop_n == 2'd2) ? 32'd4 : 32'd0);
`ifdef COMPRESSED_EN
        drop_d  = drop_q;
        if (accept && drop_q) begin
            drop_d = 1'b0;
        end
        if (flush) begin
            drop_d = flush_pc[1];
        end
`else
        fault_d = fault_q;
        block_d = block_q;
        if (consume && fault_q) begin
            fault_d = 1'b0;
            block_d = 1'b1;
        end
        if (flush) begin
            fault_d = flush_pc[1];
            block_d = 1'b0;
        end
`endif
        if (flush) begin
            count_d = '0;
            pc_d    = {flush_pc[31:1], 1'b0};
        end
    end

    // Control state with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            count_q <= '0;
            pc_q    <= RESET_PC;
`ifdef COMPRESSED_EN
            drop_q  <= RESET_PC[1];
`else
            fault_q <= 1'b0;
            block_q <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
`ifdef COMPRESSED_EN
            drop_q  <= drop_d;
`else
            fault_q <= fault_d;
            block_q <= block_d;
`endif
        end
    end

    // Halfword storage; contents beyond count are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BUF_HW); i++) begin
            hw_q[i] <= hw_d[i];
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Table-driven bench for instr_aligner. Each row drives one cycle of inputs and lists the
// outputs expected from the state present during that cycle.
module tb_instr_aligner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_compressed;
    logic        instr_fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_aligner #(
        .BUF_HW  (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .word_valid      (word_valid),
        .word_data       (word_data),
        .word_ready      (word_ready),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .instr_pc        (instr_pc),
        .instr_compressed(instr_compressed),
        .instr_fault     (instr_fault)
    );

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        fl;
        logic [31:0] fpc;
        logic        rdy;
        logic        wr;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        cmp;
        logic        flt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wv, input logic [31:0] wd, input logic fl,
                       input logic [31:0] fpc, input logic rdy, input logic wr,
                       input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic cmp, input logic flt);
        vec_t v;
        v.wv = wv; v.wd = wd; v.fl = fl; v.fpc = fpc; v.rdy = rdy;
        v.wr = wr; v.iv = iv; v.ins = ins; v.pc = pc; v.cmp = cmp; v.flt = flt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %h expected %h", row, nm, got, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [31:0] wd, input logic fl,
                         input logic [31:0] fpc, input logic rdy);
        word_valid  = wv;
        word_data   = wd;
        flush       = fl;
        flush_pc    = fpc;
        instr_ready = rdy;
    endtask

    initial begin
        //   wv  wd            fl  fpc            rdy  wr  iv  ins           pc            c  f
`ifdef COMPRESSED_EN
        add(1, 32'h0041_0093, 0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_0000, 0, 0);
        add(1, 32'h0020_8133, 0, 32'h0,        1,   1,  1, 32'h0041_0093, 32'h0000_0000, 0, 0);
        add(1, 32'h4505_4501, 0, 32'h0,        1,   1,  1, 32'h0020_8133, 32'h0000_0004, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  1, 32'h0000_4501, 32'h0000_0008, 1, 0);
        add(1, 32'h0093_4501, 0, 32'h0,        1,   1,  1, 32'h0000_4505, 32'h0000_000A, 1, 0);
        add(1, 32'h4505_0041, 0, 32'h0,        1,   1,  1, 32'h0000_4501, 32'h0000_000C, 1, 0);
        add(0, 32'h0,         0, 32'h0,        1,   0,  1, 32'h0041_0093, 32'h0000_000E, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  1, 32'h0000_4505, 32'h0000_0012, 1, 0);
        add(1, 32'h1234_0013, 1, 32'h106,      1,   1,  0, 32'h0,        32'h0000_0014, 0, 0);
        add(1, 32'h4585_FFFF, 0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_0106, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  1, 32'h0000_4585, 32'h0000_0106, 1, 0);
        add(0, 32'h0,         1, 32'h10A,      1,   1,  0, 32'h0,        32'h0000_0108, 0, 0);
        add(1, 32'h0093_FFFF, 0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_010A, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_010A, 0, 0);
        add(1, 32'h4585_0041, 0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_010A, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   0,  1, 32'h0041_0093, 32'h0000_010A, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  1, 32'h0000_4585, 32'h0000_010E, 1, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_0110, 0, 0);
`else
        // Two back-to-back 32-bit instructions.
        add(1, 32'h0041_0093, 0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_0000, 0, 0);
        add(1, 32'h0020_8133, 0, 32'h0,        1,   1,  1, 32'h0041_0093, 32'h0000_0000, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  1, 32'h0020_8133, 32'h0000_0004, 0, 0);
        // Stall with words streaming: buffer fills, word_ready drops, outputs hold.
        add(1, 32'hAAAA_0013, 0, 32'h0,        0,   1,  0, 32'h0,        32'h0000_0008, 0, 0);
        add(1, 32'hBBBB_0013, 0, 32'h0,        0,   1,  1, 32'hAAAA_0013, 32'h0000_0008, 0, 0);
        add(1, 32'hBBBB_0013, 0, 32'h0,        0,   0,  1, 32'hAAAA_0013, 32'h0000_0008, 0, 0);
        add(1, 32'hBBBB_0013, 0, 32'h0,        0,   0,  1, 32'hAAAA_0013, 32'h0000_0008, 0, 0);
        add(1, 32'hBBBB_0013, 0, 32'h0,        0,   0,  1, 32'hAAAA_0013, 32'h0000_0008, 0, 0);
        add(1, 32'hBBBB_0013, 0, 32'h0,        1,   0,  1, 32'hAAAA_0013, 32'h0000_0008, 0, 0);
        add(1, 32'hCCCC_0013, 0, 32'h0,        1,   1,  1, 32'hBBBB_0013, 32'h0000_000C, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  1, 32'hCCCC_0013, 32'h0000_0010, 0, 0);
        // Word-aligned redirect; the word accepted in the flush cycle is dropped.
        add(1, 32'hDEAD_0013, 1, 32'h100,      0,   1,  0, 32'h0,        32'h0000_0014, 0, 0);
        add(1, 32'h0050_0093, 0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_0100, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  1, 32'h0050_0093, 32'h0000_0100, 0, 0);
        // Redirect to a halfword target while consuming: sticky fault for one consume.
        add(1, 32'h0060_0093, 0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_0104, 0, 0);
        add(1, 32'h7777_0013, 1, 32'h203,      1,   1,  1, 32'h0060_0093, 32'h0000_0104, 0, 0);
        add(1, 32'h0070_0093, 0, 32'h0,        0,   1,  1, 32'h0,        32'h0000_0202, 0, 1);
        add(0, 32'h0,         0, 32'h0,        0,   1,  1, 32'h0,        32'h0000_0202, 0, 1);
        add(0, 32'h0,         0, 32'h0,        1,   1,  1, 32'h0,        32'h0000_0202, 0, 1);
        add(1, 32'h0080_0093, 0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_0202, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_0202, 0, 0);
        add(0, 32'h0,         1, 32'h300,      1,   1,  0, 32'h0,        32'h0000_0202, 0, 0);
        add(1, 32'h0090_0093, 0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_0300, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  1, 32'h0090_0093, 32'h0000_0300, 0, 0);
        // PC wraps past the top of the address space.
        add(0, 32'h0,         1, 32'hFFFF_FFFC, 1,  1,  0, 32'h0,        32'h0000_0304, 0, 0);
        add(1, 32'h00A0_0093, 0, 32'h0,        1,   1,  0, 32'h0,        32'hFFFF_FFFC, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  1, 32'h00A0_0093, 32'hFFFF_FFFC, 0, 0);
        add(0, 32'h0,         0, 32'h0,        1,   1,  0, 32'h0,        32'h0000_0000, 0, 0);
`endif

        // Reset: word_ready is low while reset is asserted.
        reset_n = 1'b1;
        drive(0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset word_ready", -1, 32'(word_ready), 32'h0);
        chk("reset instr_valid", -1, 32'(instr_valid), 32'h0);
        chk("reset instruction", -1, instruction, 32'h0);
        chk("reset instr_pc", -1, instr_pc, 32'h0);
        chk("reset instr_compressed", -1, 32'(instr_compressed), 32'h0);
        chk("reset instr_fault", -1, 32'(instr_fault), 32'h0);
        reset_n = 1'b0;

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            drive(vecs[r].wv, vecs[r].wd, vecs[r].fl, vecs[r].fpc, vecs[r].rdy);
            #1;
            chk("word_ready", r, 32'(word_ready), 32'(vecs[r].wr));
            chk("instr_valid", r, 32'(instr_valid), 32'(vecs[r].iv));
            chk("instruction", r, instruction, vecs[r].ins);
            chk("instr_pc", r, instr_pc, vecs[r].pc);
            chk("instr_compressed", r, 32'(instr_compressed), 32'(vecs[r].cmp));
            chk("instr_fault", r, 32'(instr_fault), 32'(vecs[r].flt));
        end

        // Reset mid-operation: buffered word is lost, nothing partial is emitted.
        @(negedge clk);
        drive(1, 32'h00B0_0093, 0, 32'h0, 0);
        @(negedge clk);
        drive(0, 32'h0, 0, 32'h0, 0);
        reset_n = 1'b1;
        #1;
        chk("midreset word_ready", -2, 32'(word_ready), 32'h0);
        chk("midreset pre-edge valid", -2, 32'(instr_valid), 32'h1);
        @(negedge clk);
        #1;
        chk("midreset instr_valid", -2, 32'(instr_valid), 32'h0);
        chk("midreset instr_pc", -2, instr_pc, 32'h0);
        chk("midreset instruction", -2, instruction, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("postreset word_ready", -2, 32'(word_ready), 32'h1);
        @(negedge clk);
        #1;
        chk("postreset instr_valid", -2, 32'(instr_valid), 32'h0);
        chk("postreset instr_pc", -2, instr_pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
